serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, one full-adder stage, LSB first
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous active-high reset
//   start     request a new operation (accepted in IDLE or DONE)
//   sub       0 = A + B + Cin, 1 = A - B - Cin (captured with start)
//   A, B      operands (captured with start)
//   Cin       carry-in / borrow-in (captured with start)
//   S         result of the last completed operation
//   Cout      raw adder carry of the last completed operation (1 = no borrow on subtract)
//   overflow  two's-complement overflow of the last completed operation
//   busy      high while bits are being processed
//   done      one-cycle pulse when S/Cout/overflow are updated
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic w_a_bit;
    logic w_b_bit;
    logic w_sum_bit;
    logic w_carry_out;

    // Operand registers shift right, so the bit under work is always at [0].
    assign w_a_bit     = r_a[0];
    assign w_b_bit     = r_b[0];
    assign w_sum_bit   = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_carry_out = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1 with Cin acting as a borrow,
                        // so the initial carry is Cin inverted when sub=1.
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= Cin ^ sub;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Sum bits enter at the MSB end; after WIDTH shifts bit 0 sits at [0].
                    r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_out;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_s     <= {w_sum_bit, r_sum[WIDTH-1:1]};
                        r_cout  <= w_carry_out;
                        // r_carry here is the carry into the MSB.
                        r_ovf   <= r_carry ^ w_carry_out;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign S        = r_s;
    assign Cout     = r_cout;
    assign overflow = r_ovf;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sub;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] S;
    logic       Cout;
    logic       overflow;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .S        (S),
        .Cout     (Cout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; counts rising edges until done is seen high.
    // Returns 99 when done never arrives within the budget.
    task automatic wait_done(input int already, output int lat, output int busy_bad);
        lat = already;
        busy_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done === 1'b1) return;
            if (busy !== 1'b1) busy_bad++;
        end
        lat = 99;
    endtask

    // Applies one start cycle and leaves the bench at the negedge after the start edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        @(negedge clk);
        A = a; B = b; Cin = c; sub = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int bb;
        int dcount;
        logic [7:0] e;

        reset = 1'b1; start = 1'b0; sub = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: all outputs quiet for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {20'd0, S, Cout, overflow, busy, done}, 32'd0);
        end

        // 5A + 3C = 96, signed overflow.
        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        chk("add1_busy_after_start", busy, 1'b1);
        wait_done(0, lat, bb);
        chk("add1_latency", lat, 8);
        chk("add1_busy_during_run", bb, 0);
        chk("add1_busy_at_done", busy, 1'b0);
        chk("add1_S", S, 8'h96);
        chk("add1_Cout", Cout, 1'b0);
        chk("add1_overflow", overflow, 1'b1);
        @(negedge clk);
        chk("add1_done_one_cycle", done, 1'b0);
        chk("add1_S_held", S, 8'h96);

        // FF + 01 + 1 = 1_01.
        launch(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_done(0, lat, bb);
        chk("add2_latency", lat, 8);
        chk("add2_S", S, 8'h01);
        chk("add2_Cout", Cout, 1'b1);
        chk("add2_overflow", overflow, 1'b0);

        // 10 - 20 = F0 with borrow.
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(0, lat, bb);
        chk("sub1_latency", lat, 8);
        chk("sub1_S", S, 8'hF0);
        chk("sub1_Cout", Cout, 1'b0);
        chk("sub1_overflow", overflow, 1'b0);

        // start during RUN is ignored; start in DONE is accepted back-to-back.
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        A = 8'h7F; B = 8'h7F; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ign_S_unchanged_in_run", S, 8'hF0);
        wait_done(3, lat, bb);
        chk("ign_latency", lat, 8);
        chk("ign_S", S, 8'h02);
        chk("ign_overflow", overflow, 1'b0);
        A = 8'h7F; B = 8'h01; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_dropped", done, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        wait_done(0, lat, bb);
        chk("b2b_latency", lat, 8);
        chk("b2b_S", S, 8'h80);
        chk("b2b_overflow", overflow, 1'b1);
        chk("b2b_Cout", Cout, 1'b0);

        // Reset in the middle of RUN aborts without a result.
        launch(8'h33, 8'h44, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_S", S, 8'h00);
        chk("rst_Cout_ovf", {Cout, overflow}, 2'b00);
        chk("rst_done", done, 1'b0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("rst_no_done_pulse", dcount, 0);
        chk("rst_S_still_zero", S, 8'h00);

        // Full-adder truth table on bit 0.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            launch({7'd0, bits[2]}, {7'd0, bits[1]}, bits[0], 1'b0);
            wait_done(0, lat, bb);
            e = 8'(bits[2]) + 8'(bits[1]) + 8'(bits[0]);
            chk($sformatf("fa_%0d_S", v), S, e);
            chk($sformatf("fa_%0d_Cout", v), Cout, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
